// File: rtl/data_mem_pipe.sv
`default_nettype none
// ==========================================================================
// data_mem_pipe : byte-enabled data memory, clear sweep, RD_LAT read pipe
// Revision 1.0
// ==========================================================================
module data_mem_pipe #(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 256,
   parameter int ADDR_W     = 64,
   parameter int RD_LAT     = 1,
   parameter int INIT_CLEAR = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                mem_wr,
   input  logic                mem_re,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] byte_en,
   output logic                req_ready,
   output logic [DATA_W-1:0]   re_data,
   output logic                re_valid,
   output logic                addr_err,
   output logic                init_done
);

   localparam int               NB       = DATA_W / 8;
   localparam int               IDX_W    = $clog2(DEPTH);
   localparam logic [0:0]       ST_INIT  = 1'b0;
   localparam logic [0:0]       ST_READY = 1'b1;
   localparam logic [0:0]       ST_RST   = (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   logic [0:0]        state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              sweep_we;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [IDX_W-1:0]  idx;
   logic              oor;
   logic              wr_acc, rd_acc, err_acc;
   logic [DATA_W-1:0] rd_word;

   logic [RD_LAT-1:0] vld_q, err_q;
   logic [DATA_W-1:0] data_q [RD_LAT];

   assign idx = address[IDX_W-1:0];

   generate
      if (ADDR_W > IDX_W) begin : g_range
         assign oor = |address[ADDR_W-1:IDX_W];
      end else begin : g_norange
         assign oor = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + IDX_W'(1);
         if (cnt_q == LAST_IDX) begin
            state_d = ST_READY;
         end
      end
   end

   always_comb begin
      req_ready = (state_q == ST_READY);
      init_done = (state_q == ST_READY);
      sweep_we  = (state_q == ST_INIT);
   end

   assign wr_acc  = mem_wr & req_ready;
   assign rd_acc  = mem_re & req_ready;
   assign err_acc = (wr_acc | rd_acc) & oor;
   // Registered read of the pre-write word gives read-before-write on a shared index.
   assign rd_word = oor ? '0 : mem_q[idx];

   always_ff @(posedge clk) begin
      if (sweep_we) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_acc && !oor) begin
         for (int b = 0; b < NB; b++) begin
            if (byte_en[b]) begin
               mem_q[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Data registers load only behind a valid read so the output holds between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         err_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= rd_acc;
         err_q[0] <= err_acc;
         if (rd_acc) begin
            data_q[0] <= rd_word;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            err_q[i] <= err_q[i-1];
            if (vld_q[i-1]) begin
               data_q[i] <= data_q[i-1];
            end
         end
      end
   end

   assign re_valid = vld_q[RD_LAT-1];
   assign addr_err = err_q[RD_LAT-1];
   assign re_data  = data_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_data_mem_pipe.sv
`default_nettype none
// ==========================================================================
// tb_data_mem_pipe : scoreboard bench for data_mem_pipe (RD_LAT=3, DEPTH=256)
// Revision 1.0
// ==========================================================================
module tb_data_mem_pipe;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 64;
   localparam int RD_LAT = 3;
   localparam int NB     = DATA_W / 8;

   logic              clk;
   logic              rst_n;
   logic              mem_wr, mem_re;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] wr_data;
   logic [NB-1:0]     byte_en;
   logic              req_ready;
   logic [DATA_W-1:0] re_data;
   logic              re_valid;
   logic              addr_err;
   logic              init_done;

   typedef struct {
      int                cyc;
      logic              vld;
      logic              err;
      logic [DATA_W-1:0] data;
   } rsp_t;

   rsp_t              sb[$];
   rsp_t              exp_r;
   logic [DATA_W-1:0] mdl [DEPTH];
   logic [DATA_W-1:0] last_data;
   int                cyc      = 0;
   int                n_checks = 0;
   int                n_fail   = 0;

   data_mem_pipe #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W),
      .RD_LAT     (RD_LAT),
      .INIT_CLEAR (1)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_wr    (mem_wr),
      .mem_re    (mem_re),
      .address   (address),
      .wr_data   (wr_data),
      .byte_en   (byte_en),
      .req_ready (req_ready),
      .re_data   (re_data),
      .re_valid  (re_valid),
      .addr_err  (addr_err),
      .init_done (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Response monitor: one sample per cycle, 1 time unit after the rising edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         exp_r = sb.pop_front();
         check_eq("rsp_valid", 64'(re_valid), 64'(exp_r.vld));
         check_eq("rsp_err", 64'(addr_err), 64'(exp_r.err));
         if (exp_r.vld) begin
            check_eq("rsp_data", 64'(re_data), 64'(exp_r.data));
            last_data = exp_r.data;
         end else begin
            check_eq("hold_data", 64'(re_data), 64'(last_data));
         end
      end else begin
         check_eq("no_rsp", 64'({re_valid, addr_err}), 64'(0));
         check_eq("hold_data", 64'(re_data), 64'(last_data));
      end
   end

   task automatic issue(input logic wr, input logic re, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic [NB-1:0] be);
      rsp_t e;
      logic [7:0] ix;
      logic       oor;
      @(negedge clk);
      mem_wr  = wr;
      mem_re  = re;
      address = addr;
      wr_data = data;
      byte_en = be;
      ix  = addr[7:0];
      oor = |addr[ADDR_W-1:8];
      if (req_ready) begin
         e.cyc = cyc + RD_LAT;
         if (re) begin
            e.vld  = 1'b1;
            e.err  = oor;
            e.data = oor ? '0 : mdl[ix];
            sb.push_back(e);
         end else if (wr && oor) begin
            e.vld  = 1'b0;
            e.err  = 1'b1;
            e.data = '0;
            sb.push_back(e);
         end
         if (wr && !oor) begin
            for (int b = 0; b < NB; b++) begin
               if (be[b]) mdl[ix][8*b +: 8] = data[8*b +: 8];
            end
         end
      end
   endtask

   task automatic idle();
      @(negedge clk);
      mem_wr = 1'b0;
      mem_re = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      mem_wr    = 1'b0;
      mem_re    = 1'b0;
      sb.delete();
      last_data = '0;
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_req_ready", 64'(req_ready), 64'(0));
      check_eq("rst_init_done", 64'(init_done), 64'(0));
      check_eq("rst_re_valid", 64'(re_valid), 64'(0));
      check_eq("rst_addr_err", 64'(addr_err), 64'(0));
      check_eq("rst_re_data", 64'(re_data), 64'(0));
      rst_n = 1'b1;
   endtask

   // Counts edges until req_ready; optionally holds a read request that must be dropped.
   task automatic wait_sweep(input logic poke);
      int n;
      n       = 0;
      mem_re  = poke;
      mem_wr  = poke;
      address = 64'd3;
      wr_data = 32'hFFFF_FFFF;
      byte_en = '1;
      while (!req_ready && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      mem_re = 1'b0;
      mem_wr = 1'b0;
      check_eq("sweep_len", 64'(n), 64'(DEPTH));
      check_eq("init_done", 64'(init_done), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [ADDR_W-1:0] a;
      int                op;
      rst_n     = 1'b0;
      mem_wr    = 1'b0;
      mem_re    = 1'b0;
      address   = '0;
      wr_data   = '0;
      byte_en   = '0;
      last_data = '0;

      do_reset();
      wait_sweep(1'b1);

      issue(1'b0, 1'b1, 64'h10, '0, '0);
      issue(1'b0, 1'b1, 64'd3, '0, '0);

      issue(1'b1, 1'b0, 64'd5, 32'hDEAD_BEEF, 4'hF);
      issue(1'b1, 1'b0, 64'd5, 32'h1122_3344, 4'h5);
      issue(1'b0, 1'b1, 64'd5, '0, '0);

      issue(1'b1, 1'b0, 64'd1, 32'hA, 4'hF);
      issue(1'b1, 1'b0, 64'd2, 32'hB, 4'hF);
      issue(1'b1, 1'b0, 64'd3, 32'hC, 4'hF);
      issue(1'b0, 1'b1, 64'd1, '0, '0);
      issue(1'b0, 1'b1, 64'd2, '0, '0);
      issue(1'b0, 1'b1, 64'd3, '0, '0);

      issue(1'b1, 1'b0, 64'd7, 32'h5, 4'hF);
      issue(1'b1, 1'b1, 64'd7, 32'h9, 4'hF);
      issue(1'b0, 1'b1, 64'd7, '0, '0);

      issue(1'b0, 1'b1, 64'h100, '0, '0);
      issue(1'b1, 1'b0, 64'h100, 32'hFFFF_FFFF, 4'hF);
      issue(1'b0, 1'b1, 64'd0, '0, '0);
      issue(1'b0, 1'b1, 64'h8000_0000_0000_0005, '0, '0);
      issue(1'b1, 1'b0, 64'd5, 32'h0BAD_F00D, 4'h0);
      issue(1'b0, 1'b1, 64'd5, '0, '0);

      for (int k = 0; k < 80; k++) begin
         op = int'($urandom_range(0, 3));
         a  = 64'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) a[8 + $urandom_range(0, 55)] = 1'b1;
         issue(op[0], op[1], a, $urandom, 4'($urandom_range(0, 15)));
      end
      idle();
      repeat (RD_LAT + 2) @(negedge clk);
      check_eq("sb_drained", 64'(sb.size()), 64'(0));

      // Reset lands while a read is still in flight; its response must never appear.
      issue(1'b0, 1'b1, 64'd5, '0, '0);
      do_reset();
      wait_sweep(1'b0);
      idle();
      repeat (RD_LAT + 3) @(negedge clk);
      issue(1'b0, 1'b1, 64'd5, '0, '0);
      idle();
      repeat (RD_LAT + 2) @(negedge clk);
      check_eq("sb_drained_end", 64'(sb.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
